regfile_wr_arbiter: RTL
=======================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Parameters
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width.

Interface
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports req0_valid / req1_valid  in  1  write request valid, one per requester.
REQ-006 SHALL have ports req0_addr / req1_addr  in  ADDR_W  destination register.
REQ-007 SHALL have ports req0_data / req1_data  in  DATA_W  write data.
REQ-008 SHALL have ports req0_ready / req1_ready  out  1  request accepted this cycle (combinational).
REQ-009 SHALL have port wr_stall  in  1  register file cannot take a write this cycle.
REQ-010 SHALL have port wr_en  out  1  write strobe to register file.
REQ-011 SHALL have port wr_addr  out  ADDR_W  write address to register file.
REQ-012 SHALL have port wr_data  out  DATA_W  write data to register file.
REQ-013 SHALL have port q_addr  in  ADDR_W  forwarding query address.
REQ-014 SHALL have ports q_hit  out  1  and q_data  out  DATA_W  pending-write match and data.
REQ-015 SHALL have port wr_count  out  16  committed-write counter.

Function
REQ-016 SHALL hold one output stage (out_valid, out_addr, out_data); wr_addr/wr_data always drive out_addr/out_data.
REQ-017 SHALL drive wr_en = out_valid AND NOT wr_stall; a write commits on a clock edge where wr_en is 1.
REQ-018 SHALL treat the stage as able to accept when out_valid is 0 or wr_en is 1 (accept-while-drain).
REQ-019 SHALL grant at most one requester per cycle, only when the stage can accept; ready = grant.
REQ-020 SHALL, with one valid requester, grant it; with both valid, grant the one not granted last (round-robin).
REQ-021 SHALL update the last-grant pointer only on a grant; pointer resets to 1 so req0 wins the first conflict.
REQ-022 SHALL load the granted addr/data into the stage at the next edge, setting out_valid (latency: request cycle to wr_en = 1 cycle when not stalled).
REQ-023 SHALL, for a granted request with addr 0, assert ready but not load the stage (write dropped; pointer still updates).
REQ-024 SHALL clear out_valid on a commit with no new grant; commit plus grant in the same cycle leaves out_valid = 1 with new contents.
REQ-025 SHALL hold stage contents unchanged while wr_stall = 1 and out_valid = 1; ready stays 0 for both requesters.
REQ-026 SHALL require requesters to hold valid/addr/data stable until ready; block need not check this.
REQ-027 SHALL drive q_hit = out_valid AND out_addr == q_addr AND q_addr != 0, combinationally.
REQ-028 SHALL drive q_data = out_data when q_hit, else 0.
REQ-029 SHALL increment wr_count on each commit, saturating at 16'hFFFF.

Reset
REQ-030 SHALL, on rst = 0, immediately clear out_valid, out_addr, out_data, wr_count and set last-grant pointer to 1, independent of clk.
REQ-031 SHALL, while rst = 0, drive wr_en = 0, req0_ready = req1_ready = 0, q_hit = 0, q_data = 0.
REQ-032 SHALL discard any pending stage contents when reset asserts mid-operation; no write is committed for them.
REQ-033 SHALL resume normal arbitration on the first rising edge after rst deasserts.

Verification
REQ-034 SHALL cover: req0 valid addr 5 data 32'hDEADBEEF, no stall -> req0_ready that cycle, next cycle wr_en=1 wr_addr=5 wr_data=32'hDEADBEEF, wr_count=1 after.
REQ-035 SHALL cover: both valid continuously (addr 3 / addr 4), no stall -> grants alternate req0, req1, req0; wr_addr sequence 3, 4, 3 on consecutive cycles.
REQ-036 SHALL cover: stage loaded addr 7, wr_stall=1 for 3 cycles with req1 valid -> req1_ready=0 and wr_en=0 throughout; on stall release wr_en=1 addr 7 and req1_ready=1 same cycle.
REQ-037 SHALL cover: req0 valid addr 0 data 32'h1234 -> req0_ready=1, wr_en stays 0 next cycle, wr_count unchanged, next conflict grants req1.
REQ-038 SHALL cover: stage holds addr 9 data 32'hA5A5A5A5, q_addr=9 -> q_hit=1 q_data=32'hA5A5A5A5; q_addr=0 or 8 -> q_hit=0 q_data=0.
REQ-039 SHALL cover: rst=0 asserted mid-cycle with stage valid and stalled -> wr_en, out_valid, wr_count drop to 0 before next edge; after release no stale write appears.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Two-requester round-robin write arbiter feeding a single register-file write port
// through a one-entry output stage, with forwarding lookup and a committed-write counter.
module regfile_wr_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   input  logic              wr_stall,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] q_addr,
   output logic              q_hit,
   output logic [DATA_W-1:0] q_data,
   output logic [15:0]       wr_count
);

   logic              out_valid;
   logic [ADDR_W-1:0] out_addr;
   logic [DATA_W-1:0] out_data;
   logic              last_grant;   // 1: req1 was granted most recently
   logic              can_accept;
   logic              grant0;
   logic              grant1;
   logic              grant_any;
   logic [ADDR_W-1:0] grant_addr;
   logic [DATA_W-1:0] grant_data;

   always_comb begin
      wr_en      = rst & out_valid & ~wr_stall;
      // The stage frees up in the same cycle it commits, so a new grant can overlap the drain.
      can_accept = rst & (~out_valid | wr_en);
      grant0     = 1'b0;
      grant1     = 1'b0;
      if (can_accept) begin
         if (req0_valid && req1_valid) begin
            grant0 = last_grant;
            grant1 = ~last_grant;
         end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
         end
      end
      grant_any  = grant0 | grant1;
      grant_addr = grant1 ? req1_addr : req0_addr;
      grant_data = grant1 ? req1_data : req0_data;
      q_hit      = rst & out_valid & (out_addr == q_addr) & (q_addr != '0);
      q_data     = q_hit ? out_data : '0;
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign wr_addr    = out_addr;
   assign wr_data    = out_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid  <= 1'b0;
         out_addr   <= '0;
         out_data   <= '0;
         last_grant <= 1'b1;
         wr_count   <= '0;
      end else begin
         if (grant_any) begin
            last_grant <= grant1;
         end
         // Writes to register 0 are accepted and discarded without occupying the stage.
         if (grant_any && (grant_addr != '0)) begin
            out_valid <= 1'b1;
            out_addr  <= grant_addr;
            out_data  <= grant_data;
         end else if (wr_en) begin
            out_valid <= 1'b0;
         end
         if (wr_en && (wr_count != 16'hFFFF)) begin
            wr_count <= wr_count + 16'd1;
         end
      end
   end

endmodule
